// File: rtl/adc_sum_rr_sched.sv
// rtl/adc_sum_rr_sched.sv - round-robin presenter of ADC power sums onto one snapshot register word
// Optional: define ADC_SUM_OVR_CNT_EN to add the saturating ovr_count output.
module adc_sum_rr_sched #(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 28,
  parameter int DWELL_W = 16
) (
  input  logic                     user_clk,
  input  logic                     user_rst_n,
  input  logic                     enable,
  input  logic [DWELL_W-1:0]       dwell,
  input  logic [N_CH-1:0]          sum_valid,
  input  logic [N_CH*DATA_W-1:0]   sum_data,
  output logic [31:0]              user_data_out,
  output logic                     upd_stb,
  output logic [3:0]               grant_ch,
  output logic [N_CH-1:0]          pending,
  output logic [N_CH-1:0]          overrun,
  input  logic                     overrun_clr
`ifdef ADC_SUM_OVR_CNT_EN
  ,
  output logic [15:0]              ovr_count
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t              state;
  logic [3:0]          ptr;
  logic [DWELL_W-1:0]  cnt;
  logic [DATA_W-1:0]   sum_buf [N_CH];

  logic [3:0]          sel, hi_sel, lo_sel;
  logic [DATA_W-1:0]   sel_data, hi_data, lo_data;
  logic                hi_found;
  logic                load;
  logic [N_CH-1:0]     ovr_evt;

  // Descending scan so the lowest pending index wins, first among those at/after ptr.
  always_comb begin
    hi_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    hi_data  = '0;
    lo_data  = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (pending[j]) begin
        lo_sel  = 4'(j);
        lo_data = sum_buf[j];
        if (4'(j) >= ptr) begin
          hi_found = 1'b1;
          hi_sel   = 4'(j);
          hi_data  = sum_buf[j];
        end
      end
    end
    sel      = hi_found ? hi_sel  : lo_sel;
    sel_data = hi_found ? hi_data : lo_data;
  end

  assign load = (state == LOAD);

  always_comb begin
    ovr_evt = '0;
    for (int i = 0; i < N_CH; i++) begin
      ovr_evt[i] = sum_valid[i] & pending[i] & ~(load && (sel == 4'(i)));
    end
  end

  // Capture runs regardless of FSM state; a strobe on the channel being loaded keeps it pending.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      pending <= '0;
      overrun <= '0;
      for (int i = 0; i < N_CH; i++) sum_buf[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sum_valid[i]) begin
          sum_buf[i] <= sum_data[i*DATA_W +: DATA_W];
          pending[i] <= 1'b1;
        end else if (load && (sel == 4'(i))) begin
          pending[i] <= 1'b0;
        end
        if (ovr_evt[i])       overrun[i] <= 1'b1;
        else if (overrun_clr) overrun[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      user_data_out <= '0;
      upd_stb       <= 1'b0;
      grant_ch      <= '0;
    end else begin
      upd_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && (|pending)) state <= LOAD;
        end
        LOAD: begin
          user_data_out <= {sel, sel_data};
          grant_ch      <= sel;
          upd_stb       <= 1'b1;
          cnt           <= dwell;
          ptr           <= (sel == 4'(N_CH - 1)) ? 4'd0 : sel + 4'd1;
          state         <= HOLD;
        end
        HOLD: begin
          if (cnt != '0)                   cnt   <= cnt - 1'b1;
          else if (enable && (|pending))   state <= LOAD;
          else                             state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADC_SUM_OVR_CNT_EN
  logic [4:0]  ovr_pop;
  logic [16:0] ovr_sum;

  always_comb begin
    ovr_pop = '0;
    for (int i = 0; i < N_CH; i++) ovr_pop = ovr_pop + 5'(ovr_evt[i]);
    ovr_sum = {1'b0, ovr_count} + 17'(ovr_pop);
  end

  // Events landing in the clear cycle are still counted.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n)      ovr_count <= '0;
    else if (overrun_clr) ovr_count <= 16'(ovr_pop);
    else if (ovr_sum[16]) ovr_count <= 16'hFFFF;
    else                  ovr_count <= ovr_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_adc_sum_rr_sched.sv
// tb/tb_adc_sum_rr_sched.sv - directed self-checking bench for adc_sum_rr_sched
module tb_adc_sum_rr_sched;

  localparam int N_CH = 4;
  localparam int DW   = 28;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [15:0]      dwell;
  logic [N_CH-1:0]  sum_valid;
  logic [N_CH*DW-1:0] sum_data;
  logic [31:0]      dout;
  logic             upd;
  logic [3:0]       grant;
  logic [N_CH-1:0]  pend;
  logic [N_CH-1:0]  ovr;
  logic             clr;
`ifdef ADC_SUM_OVR_CNT_EN
  logic [15:0]      ovr_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adc_sum_rr_sched #(.N_CH(N_CH), .DATA_W(DW), .DWELL_W(16)) dut (
    .user_clk(clk),
    .user_rst_n(rst_n),
    .enable(enable),
    .dwell(dwell),
    .sum_valid(sum_valid),
    .sum_data(sum_data),
    .user_data_out(dout),
    .upd_stb(upd),
    .grant_ch(grant),
    .pending(pend),
    .overrun(ovr),
    .overrun_clr(clr)
`ifdef ADC_SUM_OVR_CNT_EN
    ,
    .ovr_count(ovr_count)
`endif
  );

  typedef struct {
    logic [3:0]        sv;
    logic [N_CH*DW-1:0] sd;
    logic [31:0]       out;
    logic              upd;
    logic [3:0]        grant;
    logic [3:0]        pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] sv, logic [N_CH*DW-1:0] sd,
                              logic [31:0] out, logic u, logic [3:0] g, logic [3:0] p);
    vec_t v;
    v.sv = sv; v.sd = sd; v.out = out; v.upd = u; v.grant = g; v.pend = p;
    return v;
  endfunction

  function automatic logic [N_CH*DW-1:0] sd1(int ch, logic [DW-1:0] val);
    logic [N_CH*DW-1:0] r;
    r = '0;
    r[ch*DW +: DW] = val;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] sv, input logic [N_CH*DW-1:0] sd);
    sum_valid = sv;
    sum_data  = sd;
    @(negedge clk);
    sum_valid = '0;
  endtask

  task automatic wait_upd(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!upd && n < 20);
    chk(nm, 64'(upd), 64'd1);
  endtask

  initial begin
    logic [3:0] zs;
    logic       quiet;
    zs = '0;
    rst_n = 1'b0; enable = 1'b1; dwell = 16'd2; sum_valid = '0; sum_data = '0; clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {dout, upd, grant, pend, ovr}, 64'd0);
`ifdef ADC_SUM_OVR_CNT_EN
    chk("reset_cnt", 64'(ovr_count), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Single-channel word, then all four strobed at once with ptr at 2.
    vecs.push_back(mk(4'b0010, sd1(1, 28'h0000ABC), 32'h0, 1'b0, 4'd0, 4'b0010));
    vecs.push_back(mk(zs, '0, 32'h0, 1'b0, 4'd0, 4'b0010));
    vecs.push_back(mk(zs, '0, 32'h10000ABC, 1'b1, 4'd1, 4'b0000));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(zs, '0, 32'h10000ABC, 1'b0, 4'd1, 4'b0000));
    vecs.push_back(mk(4'b1111, {28'd4, 28'd3, 28'd2, 28'd1}, 32'h10000ABC, 1'b0, 4'd1, 4'b1111));
    vecs.push_back(mk(zs, '0, 32'h10000ABC, 1'b0, 4'd1, 4'b1111));
    vecs.push_back(mk(zs, '0, 32'h20000003, 1'b1, 4'd2, 4'b1011));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(zs, '0, 32'h20000003, 1'b0, 4'd2, 4'b1011));
    vecs.push_back(mk(zs, '0, 32'h30000004, 1'b1, 4'd3, 4'b0011));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(zs, '0, 32'h30000004, 1'b0, 4'd3, 4'b0011));
    vecs.push_back(mk(zs, '0, 32'h00000001, 1'b1, 4'd0, 4'b0010));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(zs, '0, 32'h00000001, 1'b0, 4'd0, 4'b0010));
    vecs.push_back(mk(zs, '0, 32'h10000002, 1'b1, 4'd1, 4'b0000));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(zs, '0, 32'h10000002, 1'b0, 4'd1, 4'b0000));

    foreach (vecs[i]) begin
      step(vecs[i].sv, vecs[i].sd);
      chk($sformatf("vec%0d", i), {dout, upd, grant, pend, ovr},
          {vecs[i].out, vecs[i].upd, vecs[i].grant, vecs[i].pend, 4'b0000});
    end

    // Overrun of ch0 while ch3 is held.
    step(4'b1000, sd1(3, 28'd8));
    wait_upd("ch3_upd");
    chk("ch3_word", 64'(dout), 64'h30000008);
    step(4'b0001, sd1(0, 28'd5));
    step(4'b0001, sd1(0, 28'd6));
    chk("ovr_set", 64'(ovr), 64'b0001);
    wait_upd("ch0_upd");
    chk("ch0_newest", 64'(dout), 64'h00000006);
    chk("ovr_sticky", 64'(ovr), 64'b0001);
`ifdef ADC_SUM_OVR_CNT_EN
    chk("cnt_one", 64'(ovr_count), 64'd1);
`endif
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovr_clr", 64'(ovr), 64'd0);
`ifdef ADC_SUM_OVR_CNT_EN
    chk("cnt_clr", 64'(ovr_count), 64'd0);
`endif
    repeat (4) @(negedge clk);

    // Strobe on ch2 in the very cycle it is loaded.
    step(4'b0100, sd1(2, 28'd7));
    @(negedge clk);
    step(4'b0100, sd1(2, 28'd9));
    chk("load_coll", {dout, upd, pend, ovr}, {32'h20000007, 1'b1, 4'b0100, 4'b0000});
    wait_upd("ch2_again_upd");
    chk("ch2_again", {dout, pend, ovr}, {32'h20000009, 4'b0000, 4'b0000});

    // Enable dropped mid-hold with ch1 pending.
    step(4'b0010, sd1(1, 28'h11));
    enable = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (upd) quiet = 1'b0;
    end
    chk("dis_quiet", 64'(quiet), 64'd1);
    chk("dis_frozen", {dout, pend}, {32'h20000009, 4'b0010});
    enable = 1'b1;
    @(negedge clk);
    chk("reen_load", 64'(upd), 64'd0);
    @(negedge clk);
    chk("reen_word", {dout, upd, grant}, {32'h10000011, 1'b1, 4'd1});

    // Asynchronous reset in the middle of a hold.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {dout, upd, grant, pend, ovr}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (upd || dout != 32'h0) quiet = 1'b0;
    end
    chk("post_rst_quiet", 64'(quiet), 64'd1);
    step(4'b0001, sd1(0, 28'h55));
    wait_upd("post_rst_upd");
    chk("post_rst_word", {dout, grant}, {32'h00000055, 4'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
